// File: rtl/core_pkg.sv
// Shared core-wide constants and types used by the architectural register file
// and its checkpoint/dump machinery.
package core_pkg;
  localparam int XLEN           = 64;
  localparam int ARCH_REGS      = 32;
  localparam int CKPT_SLOTS_DEF = 4;
  localparam int ARF_CW         = (CKPT_SLOTS_DEF > 1) ? $clog2(CKPT_SLOTS_DEF) : 1;

  typedef logic [ARF_CW-1:0] arf_ckpt_id_t;

  typedef enum logic {
    ARF_DUMP_IDLE,
    ARF_DUMP_RUN
  } arf_dump_state_e;
endpackage

// File: rtl/ckpt_slot_alloc.sv
// Checkpoint slot bookkeeping: valid bits, lowest-free slot selection,
// full flag and save/free updates. Snapshot contents live in the parent.
module ckpt_slot_alloc
  import core_pkg::*;
#(
  parameter int CKPT_SLOTS = 4,
  parameter int CW         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  save_req,
  input  logic                  save_block,
  input  logic                  free_req,
  input  logic [CW-1:0]         free_id,
  output logic [CKPT_SLOTS-1:0] slot_valid,
  output logic                  save_ok,
  output logic [CW-1:0]         save_id,
  output logic                  save_fire,
  output logic                  full
);

  logic [CKPT_SLOTS-1:0] valid_q;
  logic [CKPT_SLOTS-1:0] valid_n;

  // Scan downwards so the lowest free index is the last one to be taken.
  always_comb begin
    save_id = '0;
    for (int i = CKPT_SLOTS - 1; i >= 0; i--) begin
      if (!valid_q[i]) save_id = CW'(i);
    end
  end

  assign full       = &valid_q;
  assign save_ok    = !full;
  assign save_fire  = save_req & save_ok & !save_block;
  assign slot_valid = valid_q;

  // save_id is always a currently-free slot, so it can never collide with a
  // valid slot being freed; a freed slot becomes selectable only next cycle.
  always_comb begin
    valid_n = valid_q;
    if (free_req && valid_q[free_id]) valid_n[free_id] = 1'b0;
    if (save_fire)                    valid_n[save_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_n;
  end

endmodule

// File: rtl/arch_regfile_ckpt.sv
// Architectural register file written at commit, with full-state checkpoints
// for recovery and a ready/valid register dump engine for debug.
module arch_regfile_ckpt
  import core_pkg::*;
#(
  parameter int XLEN        = core_pkg::XLEN,
  parameter int ARCH_REGS   = core_pkg::ARCH_REGS,
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 2,
  parameter int CKPT_SLOTS  = CKPT_SLOTS_DEF,
  parameter int BYPASS      = 1,
  parameter int ZERO_IDX    = 0,
  localparam int AW         = $clog2(ARCH_REGS),
  localparam int CW         = (CKPT_SLOTS > 1) ? $clog2(CKPT_SLOTS) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WRITE_PORTS-1:0]              wen,
  input  logic [WRITE_PORTS-1:0][AW-1:0]      waddr,
  input  logic [WRITE_PORTS-1:0][XLEN-1:0]    wdata,
  input  logic [READ_PORTS-1:0][AW-1:0]       raddr,
  output logic [READ_PORTS-1:0][XLEN-1:0]     rdata,
  input  logic                                ckpt_save,
  output logic                                ckpt_save_ok,
  output logic [CW-1:0]                       ckpt_save_id,
  input  logic                                ckpt_restore,
  input  logic [CW-1:0]                       ckpt_restore_id,
  input  logic                                ckpt_free,
  input  logic [CW-1:0]                       ckpt_free_id,
  output logic                                ckpt_full,
  input  logic                                dump_start,
  output logic                                dump_busy,
  output logic                                dump_valid,
  input  logic                                dump_ready,
  output logic [AW-1:0]                       dump_idx,
  output logic [XLEN-1:0]                     dump_data
);

  logic [XLEN-1:0] regs      [ARCH_REGS];
  logic [XLEN-1:0] next_regs [ARCH_REGS];
  logic [XLEN-1:0] snap      [CKPT_SLOTS][ARCH_REGS];

  logic [CKPT_SLOTS-1:0] slot_valid;
  logic                  save_fire;
  logic                  restore_fire;

  arf_dump_state_e state_q, state_n;
  logic [AW-1:0]   idx_n;

  ckpt_slot_alloc #(
    .CKPT_SLOTS (CKPT_SLOTS),
    .CW         (CW)
  ) u_alloc (
    .clk        (clk),
    .reset      (reset),
    .save_req   (ckpt_save),
    .save_block (ckpt_restore),
    .free_req   (ckpt_free),
    .free_id    (ckpt_free_id),
    .slot_valid (slot_valid),
    .save_ok    (ckpt_save_ok),
    .save_id    (ckpt_save_id),
    .save_fire  (save_fire),
    .full       (ckpt_full)
  );

  assign restore_fire = ckpt_restore & slot_valid[ckpt_restore_id];

  // Post-write view of the file; ascending port order lets the youngest win.
  always_comb begin
    for (int r = 0; r < ARCH_REGS; r++) next_regs[r] = regs[r];
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (wen[p] && (waddr[p] != AW'(ZERO_IDX))) next_regs[waddr[p]] = wdata[p];
    end
  end

  always_comb begin
    for (int rp = 0; rp < READ_PORTS; rp++) begin
      rdata[rp] = regs[raddr[rp]];
      if (BYPASS != 0) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (wen[p] && (waddr[p] == raddr[rp])) rdata[rp] = wdata[p];
        end
      end
      if (raddr[rp] == AW'(ZERO_IDX)) rdata[rp] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ARCH_REGS; r++) regs[r] <= '0;
    end else if (restore_fire) begin
      for (int r = 0; r < ARCH_REGS; r++) regs[r] <= snap[ckpt_restore_id][r];
    end else begin
      for (int r = 0; r < ARCH_REGS; r++) regs[r] <= next_regs[r];
    end
  end

  always_ff @(posedge clk) begin
    if (save_fire) begin
      for (int r = 0; r < ARCH_REGS; r++) snap[ckpt_save_id][r] <= next_regs[r];
    end
  end

  // Dump engine: dump_valid is a pure function of registered state.
  always_comb begin
    state_n = state_q;
    idx_n   = dump_idx;
    case (state_q)
      ARF_DUMP_IDLE: begin
        if (dump_start) begin
          state_n = ARF_DUMP_RUN;
          idx_n   = '0;
        end
      end
      ARF_DUMP_RUN: begin
        if (dump_ready) begin
          if (dump_idx == AW'(ARCH_REGS - 1)) state_n = ARF_DUMP_IDLE;
          else                                idx_n   = dump_idx + AW'(1);
        end
        if (restore_fire) state_n = ARF_DUMP_IDLE;
      end
      default: state_n = ARF_DUMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARF_DUMP_IDLE;
      dump_idx <= '0;
    end else begin
      state_q  <= state_n;
      dump_idx <= idx_n;
    end
  end

  assign dump_busy  = (state_q == ARF_DUMP_RUN);
  assign dump_valid = dump_busy;
  assign dump_data  = (dump_idx == AW'(ZERO_IDX)) ? '0 : regs[dump_idx];

endmodule

// File: tb/tb_arch_regfile_ckpt.sv
// Directed bench for arch_regfile_ckpt: read/write vector table plus
// hand-written checkpoint and dump sequences.
module tb_arch_regfile_ckpt;
  import core_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           wen;
  logic [1:0][4:0]      waddr;
  logic [1:0][63:0]     wdata;
  logic [1:0][4:0]      raddr;
  logic [1:0][63:0]     rdata;
  logic                 ckpt_save;
  logic                 ckpt_save_ok;
  arf_ckpt_id_t         ckpt_save_id;
  logic                 ckpt_restore;
  arf_ckpt_id_t         ckpt_restore_id;
  logic                 ckpt_free;
  arf_ckpt_id_t         ckpt_free_id;
  logic                 ckpt_full;
  logic                 dump_start;
  logic                 dump_busy;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [4:0]           dump_idx;
  logic [63:0]          dump_data;

  arch_regfile_ckpt dut (
    .clk             (clk),
    .reset           (reset),
    .wen             (wen),
    .waddr           (waddr),
    .wdata           (wdata),
    .raddr           (raddr),
    .rdata           (rdata),
    .ckpt_save       (ckpt_save),
    .ckpt_save_ok    (ckpt_save_ok),
    .ckpt_save_id    (ckpt_save_id),
    .ckpt_restore    (ckpt_restore),
    .ckpt_restore_id (ckpt_restore_id),
    .ckpt_free       (ckpt_free),
    .ckpt_free_id    (ckpt_free_id),
    .ckpt_full       (ckpt_full),
    .dump_start      (dump_start),
    .dump_busy       (dump_busy),
    .dump_valid      (dump_valid),
    .dump_ready      (dump_ready),
    .dump_idx        (dump_idx),
    .dump_data       (dump_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [63:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [63:0] e0, e1;
  } vec_t;

  vec_t vecs [7];
  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [63:0] d);
    wen = 2'b01; waddr[0] = a; wdata[0] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int beat;
    int cyc;
    bit done;
    bit found;

    reset = 1'b1; wen = '0; waddr = '0; wdata = '0; raddr = '0;
    ckpt_save = 0; ckpt_restore = 0; ckpt_restore_id = '0;
    ckpt_free = 0; ckpt_free_id = '0; dump_start = 0; dump_ready = 0;

    vecs[0] = '{2'b11, 5'd5, 5'd5, 64'hAAAA, 64'hBBBB, 5'd5, 5'd0, 64'hBBBB, 64'h0};
    vecs[1] = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    5'd5, 5'd5, 64'hBBBB, 64'hBBBB};
    vecs[2] = '{2'b01, 5'd0, 5'd0, 64'h1234, 64'h0,    5'd0, 5'd5, 64'h0,    64'hBBBB};
    vecs[3] = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    5'd0, 5'd1, 64'h0,    64'h0};
    vecs[4] = '{2'b11, 5'd7, 5'd7, 64'h6666, 64'h7777, 5'd7, 5'd8, 64'h7777, 64'h0};
    vecs[5] = '{2'b01, 5'd8, 5'd0, 64'h88,   64'h0,    5'd7, 5'd8, 64'h7777, 64'h88};
    vecs[6] = '{2'b00, 5'd0, 5'd0, 64'h0,    64'h0,    5'd8, 5'd9, 64'h88,   64'h0};

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    for (int a = 0; a < 32; a += 2) begin
      raddr[0] = 5'(a); raddr[1] = 5'(a + 1);
      @(negedge clk);
      chk($sformatf("reset_r%0d", a), rdata[0], 64'h0);
      chk($sformatf("reset_r%0d", a + 1), rdata[1], 64'h0);
      tick();
    end
    chk("reset_save_ok", ckpt_save_ok, 1);
    chk("reset_save_id", ckpt_save_id, 0);
    chk("reset_full", ckpt_full, 0);
    chk("reset_busy", dump_busy, 0);
    chk("reset_valid", dump_valid, 0);

    // Write/read/bypass table
    for (int v = 0; v < 7; v++) begin
      wen = vecs[v].wen;
      waddr[0] = vecs[v].wa0; waddr[1] = vecs[v].wa1;
      wdata[0] = vecs[v].wd0; wdata[1] = vecs[v].wd1;
      raddr[0] = vecs[v].ra0; raddr[1] = vecs[v].ra1;
      @(negedge clk);
      chk($sformatf("vec%0d_rd0", v), rdata[0], vecs[v].e0);
      chk($sformatf("vec%0d_rd1", v), rdata[1], vecs[v].e1);
      tick();
    end
    wen = '0;

    // Save, overwrite, restore with a colliding write
    wr1(5'd3, 64'h11); tick();
    wen = '0; ckpt_save = 1;
    @(negedge clk); chk("save_first_id", ckpt_save_id, 0);
    tick();
    ckpt_save = 0; wr1(5'd3, 64'h22); tick();
    wr1(5'd4, 64'h99); ckpt_restore = 1; ckpt_restore_id = 0; tick();
    wen = '0; ckpt_restore = 0; raddr[0] = 5'd3; raddr[1] = 5'd4;
    @(negedge clk);
    chk("restore_r3", rdata[0], 64'h11);
    chk("restore_r4_dropped", rdata[1], 64'h0);
    chk("restore_keeps_slot", ckpt_save_id, 1);
    tick();

    // Snapshot includes same-cycle write
    ckpt_save = 1; wr1(5'd9, 64'h55);
    @(negedge clk); chk("save2_id", ckpt_save_id, 1);
    tick();
    ckpt_save = 0; wr1(5'd9, 64'h66); tick();
    wen = '0; raddr[0] = 5'd9;
    @(negedge clk); chk("r9_overwritten", rdata[0], 64'h66);
    tick();
    ckpt_restore = 1; ckpt_restore_id = 1; tick();
    ckpt_restore = 0;
    @(negedge clk); chk("r9_postwrite_snap", rdata[0], 64'h55);
    tick();

    ckpt_free = 1; ckpt_free_id = 0; tick();
    ckpt_free_id = 1; tick();
    ckpt_free = 0;
    @(negedge clk); chk("freed_save_id", ckpt_save_id, 0);
    tick();

    // Restore of an invalid slot lets writes through
    ckpt_restore = 1; ckpt_restore_id = 2; wr1(5'd10, 64'hAA); tick();
    ckpt_restore = 0; wen = '0; raddr[0] = 5'd10;
    @(negedge clk); chk("restore_invalid_noop", rdata[0], 64'hAA);
    tick();

    // Fill all slots
    ckpt_save = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk($sformatf("fill_id%0d", k), ckpt_save_id, 64'(k));
      tick();
    end
    @(negedge clk);
    chk("full_flag", ckpt_full, 1);
    chk("full_save_ok", ckpt_save_ok, 0);
    tick();
    ckpt_save = 0;
    @(negedge clk); chk("full_after_5th", ckpt_full, 1);
    ckpt_free = 1; ckpt_free_id = 2;
    tick();
    ckpt_free = 0;
    @(negedge clk);
    chk("free2_save_id", ckpt_save_id, 2);
    chk("free2_not_full", ckpt_full, 0);
    tick();

    // Free and save together: the freed slot is not picked this cycle
    ckpt_free = 1; ckpt_free_id = 0; ckpt_save = 1;
    @(negedge clk); chk("freesave_id", ckpt_save_id, 2);
    tick();
    ckpt_free = 0; ckpt_save = 0;
    @(negedge clk);
    chk("freesave_next_id", ckpt_save_id, 0);
    chk("freesave_not_full", ckpt_full, 0);
    tick();
    ckpt_free = 1;
    for (int k = 1; k < 4; k++) begin
      ckpt_free_id = 2'(k); tick();
    end
    ckpt_free = 0;

    // Dump with back-pressure
    for (int i = 0; i < 32; i += 2) begin
      wen = 2'b11;
      waddr[0] = 5'(i);     wdata[0] = 64'(i * 16);
      waddr[1] = 5'(i + 1); wdata[1] = 64'((i + 1) * 16);
      tick();
    end
    wen = '0;
    dump_start = 1; tick();
    dump_start = 0;
    chk("dump_busy_start", dump_busy, 1);
    beat = 0; cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      dump_ready = (cyc % 3 != 1);
      @(negedge clk);
      if (dump_valid !== 1'b1) begin
        chk("dump_valid_run", dump_valid, 1);
        done = 1;
      end else begin
        chk($sformatf("dump_idx_b%0d", beat), dump_idx, 64'(beat));
        chk($sformatf("dump_data_b%0d", beat), dump_data, 64'(beat * 16));
        if (dump_ready) begin
          if (beat == 31) done = 1;
          beat++;
        end
      end
      tick();
      cyc++;
    end
    dump_ready = 0;
    chk("dump_beats", 64'(beat), 64'd32);
    chk("dump_busy_end", dump_busy, 0);
    chk("dump_valid_end", dump_valid, 0);

    // Abort a running dump by restoring
    ckpt_save = 1; tick();
    ckpt_save = 0; wr1(5'd1, 64'hDEAD); tick();
    wen = '0; dump_ready = 1; dump_start = 1; tick();
    dump_start = 0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dump_idx == 5'd7) found = 1;
      else tick();
    end
    chk("abort_reached_idx7", 64'(found), 1);
    ckpt_restore = 1; ckpt_restore_id = 0;
    tick();
    ckpt_restore = 0; dump_ready = 0; raddr[0] = 5'd1;
    chk("abort_busy", dump_busy, 0);
    chk("abort_valid", dump_valid, 0);
    @(negedge clk); chk("abort_restored_r1", rdata[0], 64'h10);
    tick();
    dump_start = 1; tick();
    dump_start = 0;
    @(negedge clk);
    chk("restart_idx0", dump_idx, 0);
    chk("restart_data0", dump_data, 0);
    tick();
    dump_ready = 1;
    @(negedge clk); chk("restart_hold_idx", dump_idx, 0);
    tick();
    dump_start = 1;
    @(negedge clk);
    chk("restart_idx1", dump_idx, 1);
    chk("restart_data1", dump_data, 64'h10);
    tick();
    dump_start = 0;
    @(negedge clk); chk("start_ignored_run", dump_idx, 2);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
